// File: rtl/dvi_tx_pkg.sv
// Shared definitions for the DVI transmit link sequencer: state encoding and TMDS control tokens.
package dvi_tx_pkg;

  typedef enum logic [1:0] {
    LS_WAIT_LOCK  = 2'd0,
    LS_RESET_HOLD = 2'd1,
    LS_SETTLE     = 2'd2,
    LS_ACTIVE     = 2'd3
  } link_state_t;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dvi_tx_sync2.sv
// Two-flop synchronizer for a single asynchronous level; clears to 0 on reset.
module dvi_tx_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= 1'b0;
      q       <= 1'b0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/dvi_tx_link_sequencer.sv
// Start-up / recovery sequencer for a 3-lane DVI TMDS PHY: qualifies lock and HPD, holds the
// serializers in reset, sends control tokens while the link settles, then passes encoder data.
module dvi_tx_link_sequencer
  import dvi_tx_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 16,
  parameter int RESET_CYCLES       = 8,
  parameter int SETTLE_CYCLES      = 32,
  parameter int USE_HPD            = 1
) (
  input  logic       pixel_clock,
  input  logic       reset_n,
  input  logic       pll_lock,
  input  logic       hpd,
  input  logic       tx_enable,
  input  logic [9:0] enc_data0,
  input  logic [9:0] enc_data1,
  input  logic [9:0] enc_data2,
  output logic       phy_reset,
  output logic [9:0] phy_data0,
  output logic [9:0] phy_data1,
  output logic [9:0] phy_data2,
  output logic       video_ready,
  output logic [1:0] link_state,
  output logic [7:0] relock_count
);

  localparam int CNT_MAX = max3(LOCK_STABLE_CYCLES, RESET_CYCLES, SETTLE_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic HPD_GATE = (USE_HPD != 0);

  logic lock_s, hpd_s, qual, link_loss;
  link_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  dvi_tx_sync2 u_sync_lock (.clk(pixel_clock), .rst_n(reset_n), .d(pll_lock), .q(lock_s));
  dvi_tx_sync2 u_sync_hpd  (.clk(pixel_clock), .rst_n(reset_n), .d(hpd),      .q(hpd_s));

  assign qual = lock_s & (hpd_s | ~HPD_GATE) & tx_enable;
  // Only physical link loss counts as a relock; a software disable does not.
  assign link_loss = (state == LS_ACTIVE) & ~qual & (~lock_s | (HPD_GATE & ~hpd_s));
  assign link_state = state;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    case (state)
      LS_WAIT_LOCK: begin
        if (!qual) begin
          cnt_nxt = '0;
        end else if (cnt == LOCK_LAST) begin
          state_nxt = LS_RESET_HOLD;
          cnt_nxt   = '0;
        end
      end
      LS_RESET_HOLD: begin
        if (!qual) begin
          state_nxt = LS_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == RESET_LAST) begin
          state_nxt = LS_SETTLE;
          cnt_nxt   = '0;
        end
      end
      LS_SETTLE: begin
        if (!qual) begin
          state_nxt = LS_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == SETTLE_LAST) begin
          state_nxt = LS_ACTIVE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        cnt_nxt = '0;
        if (!qual) state_nxt = LS_WAIT_LOCK;
      end
    endcase
  end

  // Outputs are registered from the next state so they move on the same edge as the state.
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= LS_WAIT_LOCK;
      cnt          <= '0;
      phy_reset    <= 1'b1;
      video_ready  <= 1'b0;
      phy_data0    <= CTRL_TOKEN_00;
      phy_data1    <= CTRL_TOKEN_00;
      phy_data2    <= CTRL_TOKEN_00;
      relock_count <= 8'h00;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      phy_reset   <= (state_nxt == LS_WAIT_LOCK) || (state_nxt == LS_RESET_HOLD);
      video_ready <= (state_nxt == LS_ACTIVE);
      if (state_nxt == LS_ACTIVE) begin
        phy_data0 <= enc_data0;
        phy_data1 <= enc_data1;
        phy_data2 <= enc_data2;
      end else begin
        phy_data0 <= CTRL_TOKEN_00;
        phy_data1 <= CTRL_TOKEN_00;
        phy_data2 <= CTRL_TOKEN_00;
      end
      if (link_loss && (relock_count != 8'hFF)) relock_count <= relock_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_dvi_tx_link_sequencer.sv
// Scoreboard bench for dvi_tx_link_sequencer: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_dvi_tx_link_sequencer;
  import dvi_tx_pkg::*;

  logic       pixel_clock = 1'b0;
  logic       reset_n     = 1'b0;
  logic       pll_lock    = 1'b1;
  logic       hpd         = 1'b1;
  logic       hpd_off     = 1'b0;
  logic       tx_enable   = 1'b1;
  logic [9:0] enc0        = 10'h000;
  logic [9:0] enc1, enc2;

  logic       a_rst, a_vr, b_rst, b_vr;
  logic [9:0] a_d0, a_d1, a_d2, b_d0, b_d1, b_d2;
  logic [1:0] a_ls, b_ls;
  logic [7:0] a_rc, b_rc;

  assign enc1 = enc0 + 10'd1;
  assign enc2 = enc0 + 10'd2;

  dvi_tx_link_sequencer #(.USE_HPD(1)) dut (
    .pixel_clock(pixel_clock), .reset_n(reset_n), .pll_lock(pll_lock), .hpd(hpd),
    .tx_enable(tx_enable), .enc_data0(enc0), .enc_data1(enc1), .enc_data2(enc2),
    .phy_reset(a_rst), .phy_data0(a_d0), .phy_data1(a_d1), .phy_data2(a_d2),
    .video_ready(a_vr), .link_state(a_ls), .relock_count(a_rc));

  dvi_tx_link_sequencer #(.USE_HPD(0)) dut_nohpd (
    .pixel_clock(pixel_clock), .reset_n(reset_n), .pll_lock(pll_lock), .hpd(hpd_off),
    .tx_enable(tx_enable), .enc_data0(enc0), .enc_data1(enc1), .enc_data2(enc2),
    .phy_reset(b_rst), .phy_data0(b_d0), .phy_data1(b_d1), .phy_data2(b_d2),
    .video_ready(b_vr), .link_state(b_ls), .relock_count(b_rc));

  always #5 pixel_clock = ~pixel_clock;

  int cyc = 0;
  always @(posedge pixel_clock) cyc <= cyc + 1;

  typedef struct {
    int         at;
    int         which;
    logic [1:0] ls;
    logic       rst;
    logic       vr;
    logic [9:0] d;
    logic [7:0] rc;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   base   = 0;

  task automatic compare(input exp_t e);
    logic [1:0] ls;
    logic       rst, vr;
    logic [9:0] d0, d1, d2, e0, e1, e2;
    logic [7:0] rc;
    if (e.which == 0) begin
      ls = a_ls; rst = a_rst; vr = a_vr; d0 = a_d0; d1 = a_d1; d2 = a_d2; rc = a_rc;
    end else begin
      ls = b_ls; rst = b_rst; vr = b_vr; d0 = b_d0; d1 = b_d1; d2 = b_d2; rc = b_rc;
    end
    if (e.ls == 2'd3) begin
      e0 = e.d; e1 = e.d + 10'd1; e2 = e.d + 10'd2;
    end else begin
      e0 = CTRL_TOKEN_00; e1 = CTRL_TOKEN_00; e2 = CTRL_TOKEN_00;
    end
    checks++;
    if (ls !== e.ls || rst !== e.rst || vr !== e.vr || d0 !== e0 || d1 !== e1 ||
        d2 !== e2 || rc !== e.rc) begin
      errors++;
      $display("FAIL %s (dut%0d cyc %0d): got ls=%0d rst=%b vr=%b d=%h/%h/%h rc=%0d, want ls=%0d rst=%b vr=%b d=%h/%h/%h rc=%0d",
               e.name, e.which, cyc - base, ls, rst, vr, d0, d1, d2, rc,
               e.ls, e.rst, e.vr, e0, e1, e2, e.rc);
    end
  endtask

  task automatic expect_at(input int k, input int which, input logic [1:0] ls, input logic rst,
                           input logic vr, input logic [9:0] d, input logic [7:0] rc,
                           input string name);
    exp_t e;
    e.at = base + k; e.which = which; e.ls = ls; e.rst = rst; e.vr = vr;
    e.d = d; e.rc = rc; e.name = name;
    sb.push_back(e);
  endtask

  task automatic goto(input int k);
    while (cyc < base + k) @(negedge pixel_clock);
  endtask

  // Monitor: outputs are registered, so the falling edge sees the value after edge 'cyc'.
  initial begin
    exp_t e;
    forever begin
      @(negedge pixel_clock);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        e = sb.pop_front();
        if (e.at < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s: expectation for cyc %0d not serviced, now %0d", e.name, e.at - base, cyc - base);
        end else begin
          compare(e);
        end
      end
    end
  end

  initial begin
    exp_t r;
    int   t;
    logic [7:0] rc_exp;

    repeat (3) @(negedge pixel_clock);
    r.at = 0; r.ls = 2'd0; r.rst = 1'b1; r.vr = 1'b0; r.d = 10'h0; r.rc = 8'd0;
    r.which = 0; r.name = "reset_values";       compare(r);
    r.which = 1; r.name = "reset_values_nohpd"; compare(r);

    reset_n = 1'b1;
    base    = cyc;

    // Clean bring-up with everything qualified; lane 0 data masked in SETTLE, passed in ACTIVE.
    expect_at(2,  0, 2'd0, 1'b1, 1'b0, 10'h000, 8'd0, "wait_lock");
    expect_at(18, 0, 2'd1, 1'b1, 1'b0, 10'h000, 8'd0, "reset_hold_entry");
    expect_at(25, 0, 2'd1, 1'b1, 1'b0, 10'h000, 8'd0, "reset_hold_end");
    expect_at(26, 0, 2'd2, 1'b0, 1'b0, 10'h000, 8'd0, "phy_reset_release");
    expect_at(40, 0, 2'd2, 1'b0, 1'b0, 10'h000, 8'd0, "settle_data_masked");
    expect_at(57, 0, 2'd2, 1'b0, 1'b0, 10'h000, 8'd0, "settle_end");
    expect_at(58, 0, 2'd3, 1'b0, 1'b1, 10'h000, 8'd0, "active_entry");
    expect_at(58, 1, 2'd3, 1'b0, 1'b1, 10'h000, 8'd0, "nohpd_active_entry");
    expect_at(59, 0, 2'd3, 1'b0, 1'b1, 10'h2AA, 8'd0, "active_pass_2aa");
    expect_at(60, 0, 2'd3, 1'b0, 1'b1, 10'h155, 8'd0, "active_pass_155");
    goto(39); enc0 = 10'h2AA;
    goto(40); enc0 = 10'h000;
    goto(58); enc0 = 10'h2AA;
    goto(59); enc0 = 10'h155;

    // Software disable: immediate teardown, no relock count.
    expect_at(62,  0, 2'd0, 1'b1, 1'b0, 10'h000, 8'd0, "txen_drop");
    expect_at(78,  0, 2'd1, 1'b1, 1'b0, 10'h000, 8'd0, "txen_rehold");
    expect_at(118, 0, 2'd3, 1'b0, 1'b1, 10'h155, 8'd0, "txen_reactive");
    goto(61); tx_enable = 1'b0;
    goto(62); tx_enable = 1'b1;

    // One-cycle lock glitch at count 10 in WAIT_LOCK restarts the qualification count.
    expect_at(121, 0, 2'd0, 1'b1, 1'b0, 10'h000, 8'd0, "wait_again");
    expect_at(137, 0, 2'd0, 1'b1, 1'b0, 10'h000, 8'd0, "glitch_no_early_exit");
    expect_at(147, 0, 2'd0, 1'b1, 1'b0, 10'h000, 8'd0, "glitch_restart");
    expect_at(148, 0, 2'd1, 1'b1, 1'b0, 10'h000, 8'd0, "glitch_hold");
    expect_at(188, 0, 2'd3, 1'b0, 1'b1, 10'h155, 8'd0, "glitch_active");
    goto(120); tx_enable = 1'b0;
    goto(121); tx_enable = 1'b1;
    goto(129); pll_lock  = 1'b0;
    goto(130); pll_lock  = 1'b1;

    // Lock loss in ACTIVE: teardown on the third edge, relock_count 0 -> 1.
    expect_at(192, 0, 2'd3, 1'b0, 1'b1, 10'h155, 8'd0, "lock_drop_pending");
    expect_at(193, 0, 2'd0, 1'b1, 1'b0, 10'h000, 8'd1, "lock_drop");
    goto(190); pll_lock = 1'b0;

    // 299 further lock-loss cycles: relock_count saturates at 255.
    t = 193;
    for (int i = 0; i < 299; i++) begin
      rc_exp = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
      expect_at(t + 58, 0, 2'd3, 1'b0, 1'b1, 10'h155, rc_exp, "relock_active");
      rc_exp = (i + 2 > 255) ? 8'd255 : 8'(i + 2);
      expect_at(t + 61, 0, 2'd0, 1'b1, 1'b0, 10'h000, rc_exp, "relock_count");
      goto(t);      pll_lock = 1'b1;
      goto(t + 58); pll_lock = 1'b0;
      t += 61;
    end

    // Asynchronous reset in SETTLE.
    expect_at(t + 30, 0, 2'd2, 1'b0, 1'b0, 10'h000, 8'd255, "settle_before_reset");
    goto(t);      pll_lock = 1'b1;
    goto(t + 30);
    #2 reset_n = 1'b0;
    #1;
    r.ls = 2'd0; r.rst = 1'b1; r.vr = 1'b0; r.d = 10'h0; r.rc = 8'd0;
    r.which = 0; r.name = "async_reset";       compare(r);
    r.which = 1; r.name = "async_reset_nohpd"; compare(r);

    @(negedge pixel_clock);
    while (sb.size() > 0) begin
      r = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation for cyc %0d never serviced", r.name, r.at - base);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
